// File: rtl/sc_pkg.sv
// Shared helpers for the radix counter chain.
//   clog2       : ceiling log2, used to size digit and output buses
//   RADIX_POW   : constant integer power, used for the radical-inverse weights
//   radix_legal : true when a digit base is inside the supported range
//   digits_legal: true when a digit count is inside the supported range
package sc_pkg;

    localparam int RADIX_MIN  = 2;
    localparam int RADIX_MAX  = 16;
    localparam int DIGITS_MIN = 1;
    localparam int DIGITS_MAX = 8;

    // Minimum number of bits to hold values 0..value-1 (at least 0).
    function automatic int clog2(input longint value);
        int     r;
        longint x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // r**n evaluated with 64-bit arithmetic so 16**8 does not overflow.
    function automatic longint RADIX_POW(input int r, input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * r;
        end
        return p;
    endfunction

    function automatic bit radix_legal(input int r);
        return (r >= RADIX_MIN) && (r <= RADIX_MAX);
    endfunction

    function automatic bit digits_legal(input int n);
        return (n >= DIGITS_MIN) && (n <= DIGITS_MAX);
    endfunction

endpackage

// File: rtl/radix_digit.sv
// One base-RADIX digit of the counter chain.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   seed       : value loaded on reset; out-of-range seeds load 0
//   en         : the chain is stepping this cycle
//   dir        : 0 = up, 1 = down
//   cin        : carry (up) or borrow (down) arriving from the lower digit
//   digit      : registered digit value, always below RADIX
//   cout       : combinational carry/borrow to the next digit
module radix_digit
    import sc_pkg::*;
#(
    parameter  int RADIX = 3,
    localparam int DW    = clog2(RADIX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] seed,
    input  logic          en,
    input  logic          dir,
    input  logic          cin,
    output logic [DW-1:0] digit,
    output logic          cout
);

    localparam logic [DW-1:0] DIGIT_TOP = DW'(RADIX - 1);
    localparam logic [DW:0]   RADIX_W   = (DW + 1)'(RADIX);

    logic          at_limit;
    logic          seed_ok;
    logic [DW-1:0] next_digit;

    // The digit rolls over when it sits at the end of its range in the
    // current direction; only then does carry/borrow continue upward.
    always_comb begin
        at_limit   = dir ? (digit == '0) : (digit == DIGIT_TOP);
        cout       = cin & at_limit;
        seed_ok    = ({1'b0, seed} < RADIX_W);
        next_digit = digit;
        if (cin) begin
            if (at_limit) begin
                next_digit = dir ? DIGIT_TOP : '0;
            end else begin
                next_digit = dir ? (digit - DW'(1)) : (digit + DW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= seed_ok ? seed : '0;
        end else if (en) begin
            digit <= next_digit;
        end
    end

endmodule

// File: rtl/radix_counter_chain.sv
// DIGITS-digit base-RADIX up/down counter with wrap flag and radical inverse.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   seed       : per-digit reset value, digit i at [i*DW +: DW]
//   en         : advance one step this cycle
//   dir        : 0 = count up, 1 = count down
//   digits     : current digit registers, same packing as seed
//   vdc        : digit-reversed value, sum of digit[i]*RADIX^(DIGITS-1-i)
//   wrap       : one-cycle pulse aligned with the digits that just wrapped
module radix_counter_chain
    import sc_pkg::*;
#(
    parameter  int RADIX  = 3,
    parameter  int DIGITS = 4,
    localparam int DW     = clog2(RADIX),
    localparam int VW     = clog2(RADIX_POW(RADIX, DIGITS))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIGITS*DW-1:0] seed,
    input  logic                 en,
    input  logic                 dir,
    output logic [DIGITS*DW-1:0] digits,
    output logic [VW-1:0]        vdc,
    output logic                 wrap
);

    if (!radix_legal(RADIX)) begin : g_bad_radix
        $error("radix_counter_chain: RADIX %0d outside supported range", RADIX);
    end
    if (!digits_legal(DIGITS)) begin : g_bad_digits
        $error("radix_counter_chain: DIGITS %0d outside supported range", DIGITS);
    end

    // carry[0] is tied high: every enabled step adds or removes one unit.
    // The carry out of the top digit is the full-period wrap.
    logic [DIGITS:0] carry;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        radix_digit #(
            .RADIX (RADIX)
        ) u_digit (
            .clk   (clk),
            .reset (reset),
            .seed  (seed[i*DW +: DW]),
            .en    (en),
            .dir   (dir),
            .cin   (carry[i]),
            .digit (digits[i*DW +: DW]),
            .cout  (carry[i+1])
        );
    end

    // The wrap is only meaningful on an enabled edge, so it is gated by en.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= en & carry[DIGITS];
        end
    end

    // Radical inverse: digit 0 carries the largest weight. Weights are
    // elaboration-time constants, so each product reduces to shifts and adds.
    logic [VW-1:0] vdc_acc;

    always_comb begin
        vdc_acc = '0;
        for (int i = 0; i < DIGITS; i++) begin
            vdc_acc = vdc_acc + VW'(digits[i*DW +: DW]) *
                                VW'(RADIX_POW(RADIX, DIGITS - 1 - i));
        end
        vdc = vdc_acc;
    end

endmodule
